sd_stream_packer: RTL and testbench
===================================

# sd_stream_packer

Parametrised successor to the raw SD file byte stream path. It accepts the unthrottled `outreq`/`outbyte` strobe stream from `SDFileReader` and packs bytes little-endian into `OUT_BYTES`-wide words with per-lane keep. Words are buffered in a `DEPTH`-word FIFO and presented on a valid/ready interface, so consumers that can stall (DMA, wide RAM writers, multi-lane displays) can sit behind the file reader. Partial words are flushed explicitly or after an idle timeout, and dropped data is flagged.

## Interface
- `OUT_BYTES`, 4: bytes per output word, legal 1..8.
- `DEPTH`, 16: FIFO depth in words, power of two, ≥2.
- `IDLE_FLUSH`, 1000: idle cycles with a partial word pending before auto-flush; 0 disables auto-flush.

- `clk`  in  1  single clock for the whole block.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `inreq`  in  1  byte strobe from the file reader; one byte per high cycle, no backpressure.
- `inbyte`  in  8  byte, valid when `inreq`=1.
- `flush`  in  1  single-cycle request to emit any partial word, e.g. at end of file.
- `out_valid`  out  1  FIFO head word is valid.
- `out_ready`  in  1  consumer accepts the head word when `out_valid`&&`out_ready`.
- `out_data`  out  8*OUT_BYTES  packed word; byte k sits in bits [8k+7:8k].
- `out_keep`  out  OUT_BYTES  lane k holds a real byte; always contiguous from lane 0.
- `overflow`  out  1  sticky: a word was dropped because the FIFO was full.
- `fifo_level`  out  $clog2(DEPTH)+1  words currently stored.

## Operation
- The packer uses a lane index `idx` (0..OUT_BYTES-1), a data shift register, and a keep register. There are two states, EMPTY (`idx`=0, nothing pending) and FILL.
- On `inreq`, `inbyte` is written to lane `idx`, its keep bit is set, and `idx` increments.
- When the written lane is OUT_BYTES-1, the word completes. It is pushed with all keep bits set, `idx`→0, and the state returns to EMPTY.
- Flush: when `flush` is high, or the idle counter reaches IDLE_FLUSH, and the state is FILL, the partial word is pushed. Unfilled lanes have data=0 and keep=0. Then `idx`→0 and the state goes to EMPTY. A flush in EMPTY is a no-op; empty words are never pushed.
- `flush` and `inreq` in the same cycle: the byte is merged first, then the resulting word is pushed. If that byte completes the word, exactly one full word is pushed.
- The idle counter clears on every `inreq` and on every push. It counts only in FILL and saturates.
- The FIFO is first-word-fall-through.
  - A push is accepted if the FIFO is not full, or if a pop happens in the same cycle.
  - Otherwise the word is discarded, `overflow` is set, and the packer still returns to EMPTY.
- `overflow` clears only on reset.
- Simultaneous push and pop: `fifo_level` is unchanged, and pointers wrap modulo DEPTH.
- With OUT_BYTES=1, every byte is pushed immediately, and flush and the idle timer are inert.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_keep`=0, `overflow`=0, `fifo_level`=0. Internally `idx`=0, state EMPTY, pointers 0, idle counter 0.
- Reset asserted mid-word or mid-burst discards all pending bytes and stored words immediately; no output glitch persists past deassertion.
- Latency: a push occurs on the edge ending the completing `inreq` cycle. If the FIFO was empty, `out_valid` rises on the next cycle, so the word is visible one cycle after its last byte.
- Auto-flush: with the last `inreq` in cycle T, the push happens at the end of cycle T+IDLE_FLUSH, and `out_valid` is seen at T+IDLE_FLUSH+1.
- `out_data`/`out_keep` are stable while `out_valid`=1 and `out_ready`=0. The next word appears the cycle after a handshake.
- Sustained throughput is one byte per cycle on input and one word per cycle on output.

## Configuration
- `SD_STREAM_PACKER_STATS_EN`
  - Defined: adds output ports `byte_count` (32 bits, counts accepted `inreq` bytes) and `drop_count` (16 bits, counts discarded words). Both counters saturate at all-ones and reset to 0.
  - Undefined: neither the ports nor the counters exist, and behaviour is otherwise identical.

## Structure
- Package `sd_stream_pkg` holds:
  - the packer state enum (EMPTY, FILL);
  - the function `lvl_w(depth)` = $clog2(depth)+1;
  - the constant `SD_BYTE_W`=8.
- The single sub-module `sync_fifo_fwft` is parameterised by data width and DEPTH. It has push, pop, full, empty, and level ports and handles the same-cycle push/pop-when-full rule.
- Packer logic and the idle counter live in `sd_stream_packer` itself.

## Test plan
- OUT_BYTES=4, bytes 0x11,0x22,0x33,0x44 on consecutive cycles, `out_ready`=1 → one word 0x44332211 with keep 4'b1111, `out_valid` one cycle after the 0x44 strobe.
- Bytes 0xAA,0xBB, then `flush` → word 0x0000BBAA with keep 4'b0011. A second `flush` pushes nothing.
- IDLE_FLUSH=8, single byte 0x5A, then idle → word 0x0000005A with keep 4'b0001, `out_valid` 9 cycles after the strobe.
- DEPTH=4, `out_ready`=0, 20 bytes streamed → `fifo_level`=4, `overflow`=1, and the first four words preserved in order on drain (plus `drop_count`=1 when stats are enabled).
- FIFO full, with a completing `inreq` and a handshake in the same cycle → word accepted, `fifo_level` stays 4, `overflow` stays 0.
- `rst_n` pulsed low after 3 of 4 bytes → all outputs return to reset values. The next 4 bytes form a clean full word.

Source files
------------

// File: rtl/sd_stream_pkg.sv
// sd_stream_pkg: shared types and helpers for the SD byte-stream packer.
package sd_stream_pkg;
    localparam int SD_BYTE_W = 8;

    typedef enum logic {EMPTY, FILL} pack_state_e;

    function automatic int lvl_w(input int depth);
        return $clog2(depth) + 1;
    endfunction
endpackage

// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft: first-word-fall-through FIFO; a push into a full FIFO is
// accepted only when a pop frees the head slot in the same cycle.
module sync_fifo_fwft
    import sd_stream_pkg::*;
#(
    parameter int W     = 32,
    parameter int DEPTH = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push_i,
    input  logic [W-1:0]              wdata_i,
    input  logic                      pop_i,
    output logic                      full_o,
    output logic                      empty_o,
    output logic [W-1:0]              rdata_o,
    output logic [lvl_w(DEPTH)-1:0]   level_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = lvl_w(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [LW-1:0] lvl_q;
    logic          do_push, do_pop;

    assign empty_o = lvl_q == '0;
    assign full_o  = lvl_q == LW'(DEPTH);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign level_o = lvl_q;
    // Gated so the head reads as zero whenever nothing is stored.
    assign rdata_o = empty_o ? '0 : mem_q[rd_q];

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= wdata_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            lvl_q <= '0;
        end else begin
            wr_q  <= wr_q + AW'(do_push);
            rd_q  <= rd_q + AW'(do_pop);
            lvl_q <= lvl_q + LW'(do_push) - LW'(do_pop);
        end
    end
endmodule

// File: rtl/sd_stream_packer.sv
// sd_stream_packer: packs the SD reader byte strobe stream little-endian into
// keep-qualified words behind a FWFT FIFO. Define SD_STREAM_PACKER_STATS_EN for byte/drop counters.
module sd_stream_packer
    import sd_stream_pkg::*;
#(
    parameter int OUT_BYTES  = 4,
    parameter int DEPTH      = 16,
    parameter int IDLE_FLUSH = 1000
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            inreq,
    input  logic [SD_BYTE_W-1:0]            inbyte,
    input  logic                            flush,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [SD_BYTE_W*OUT_BYTES-1:0]  out_data,
    output logic [OUT_BYTES-1:0]            out_keep,
    output logic                            overflow,
`ifdef SD_STREAM_PACKER_STATS_EN
    output logic [31:0]                     byte_count,
    output logic [15:0]                     drop_count,
`endif
    output logic [lvl_w(DEPTH)-1:0]         fifo_level
);
    localparam int DW  = SD_BYTE_W * OUT_BYTES;
    localparam int IXW = OUT_BYTES > 1 ? $clog2(OUT_BYTES) : 1;
    localparam int IW  = IDLE_FLUSH > 0 ? $clog2(IDLE_FLUSH + 1) : 1;

    pack_state_e    state_q, state_d;
    logic [IXW-1:0] idx_q, idx_d;
    logic [DW-1:0]  data_q, data_d, data_w;
    logic [OUT_BYTES-1:0] keep_q, keep_d, keep_w;
    logic [IW-1:0]  idle_q, idle_d;
    logic           overflow_q;
    logic           last, idle_hit, push, pop, full, empty, drop;

    always_comb begin
        data_w = data_q;
        keep_w = keep_q;
        for (int k = 0; k < OUT_BYTES; k++) begin
            if (inreq && idx_q == IXW'(k)) begin
                data_w[k*SD_BYTE_W +: SD_BYTE_W] = inbyte;
                keep_w[k] = 1'b1;
            end
        end
        last     = inreq && idx_q == IXW'(OUT_BYTES - 1);
        idle_hit = IDLE_FLUSH != 0 && state_q == FILL && !inreq && idle_q == IW'(IDLE_FLUSH - 1);
        // A merged byte plus flush yields a single push, even when it completes the word.
        push     = last || ((flush || idle_hit) && (inreq || state_q == FILL));
        state_d  = push ? EMPTY : (inreq ? FILL : state_q);
        idx_d    = push ? '0 : (inreq ? idx_q + IXW'(1) : idx_q);
        data_d   = push ? '0 : data_w;
        keep_d   = push ? '0 : keep_w;
        idle_d   = (inreq || push) ? '0 :
                   (state_q == FILL && idle_q != IW'(IDLE_FLUSH)) ? idle_q + IW'(1) : idle_q;
    end

    assign pop       = out_valid && out_ready;
    assign drop      = push && full && !pop;
    assign out_valid = !empty;
    assign overflow  = overflow_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            idx_q      <= '0;
            data_q     <= '0;
            keep_q     <= '0;
            idle_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            data_q     <= data_d;
            keep_q     <= keep_d;
            idle_q     <= idle_d;
            overflow_q <= overflow_q | drop;
        end
    end

    sync_fifo_fwft #(.W(DW + OUT_BYTES), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .wdata_i ({keep_w, data_w}),
        .pop_i   (pop),
        .full_o  (full),
        .empty_o (empty),
        .rdata_o ({out_keep, out_data}),
        .level_o (fifo_level)
    );

`ifdef SD_STREAM_PACKER_STATS_EN
    logic [31:0] byte_q;
    logic [15:0] drop_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_q <= '0;
            drop_q <= '0;
        end else begin
            byte_q <= byte_q + 32'(inreq && !(&byte_q));
            drop_q <= drop_q + 16'(drop && !(&drop_q));
        end
    end

    assign byte_count = byte_q;
    assign drop_count = drop_q;
`endif
endmodule

// File: tb/tb_sd_stream_packer.sv
// tb_sd_stream_packer: directed scenarios plus randomized traffic checked
// against a byte-queue/word-queue model of the packer and FIFO.
module tb_sd_stream_packer;
    typedef struct {
        logic [31:0] d;
        logic [3:0]  k;
    } word_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       inreq = 1'b0;
    logic [7:0] inbyte = '0;
    logic       flush = 1'b0;
    logic       out_ready = 1'b0;
    logic       out_valid;
    logic [31:0] out_data;
    logic [3:0] out_keep;
    logic       overflow;
    logic [2:0] fifo_level;
`ifdef SD_STREAM_PACKER_STATS_EN
    logic [31:0] byte_count;
    logic [15:0] drop_count;
`endif

    int checks = 0;
    int errors = 0;

    logic [7:0] pend[$];
    word_t      mq[$];
    int         idle_m = 0;
    bit         ovf_m = 0;
    int         drops_m = 0;
    int         bytes_m = 0;

    sd_stream_packer #(.OUT_BYTES(4), .DEPTH(4), .IDLE_FLUSH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .inreq      (inreq),
        .inbyte     (inbyte),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_keep   (out_keep),
        .overflow   (overflow),
`ifdef SD_STREAM_PACKER_STATS_EN
        .byte_count (byte_count),
        .drop_count (drop_count),
`endif
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    // One clock cycle of stimulus; the model advances by the same cycle.
    task automatic drive(input bit rq, input logic [7:0] b, input bit fl, input bit rdy);
        bit    pop, push;
        word_t w;
        @(negedge clk);
        inreq = rq; inbyte = b; flush = fl; out_ready = rdy;
        pop  = mq.size() > 0 && rdy;
        push = 0;
        w.d = '0; w.k = '0;
        if (rq) begin
            pend.push_back(b);
            idle_m = 0;
            bytes_m++;
        end else if (pend.size() > 0) idle_m++;
        if (pend.size() == 4 || (pend.size() > 0 && (fl || idle_m == 8))) begin
            push = 1;
            foreach (pend[i]) begin
                w.d[8*i +: 8] = pend[i];
                w.k[i] = 1'b1;
            end
            pend.delete();
            idle_m = 0;
        end
        if (push && mq.size() == 4 && !pop) begin
            ovf_m = 1;
            drops_m++;
            push = 0;
        end
        if (pop) void'(mq.pop_front());
        if (push) mq.push_back(w);
        @(posedge clk);
        #1;
    endtask

    task automatic reset_assert();
        inreq = 0; flush = 0; out_ready = 0;
        rst_n = 1'b0;
        #2;
        pend.delete(); mq.delete();
        idle_m = 0; ovf_m = 0; drops_m = 0; bytes_m = 0;
    endtask

    task automatic reset_release();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_assert();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_data got %h want 0", out_data); end
        checks++; if (out_keep !== 4'h0) begin errors++; $display("FAIL reset_keep got %b want 0", out_keep); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
        checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL reset_level got %0d want 0", fifo_level); end
        reset_release();
    endtask

    task automatic test_full_word();
        drive(1, 8'h11, 0, 1);
        drive(1, 8'h22, 0, 1);
        drive(1, 8'h33, 0, 1);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL full_early_valid got %b want 0", out_valid); end
        drive(1, 8'h44, 0, 1);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL full_valid got %b want 1", out_valid); end
        checks++; if (out_data !== 32'h44332211) begin errors++; $display("FAIL full_data got %h want 44332211", out_data); end
        checks++; if (out_keep !== 4'b1111) begin errors++; $display("FAIL full_keep got %b want 1111", out_keep); end
        drive(0, 8'h00, 0, 1);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL full_popped got %b want 0", out_valid); end
    endtask

    task automatic test_flush();
        drive(1, 8'hAA, 0, 0);
        drive(1, 8'hBB, 0, 0);
        drive(0, 8'h00, 1, 0);
        checks++; if (out_data !== 32'h0000BBAA) begin errors++; $display("FAIL flush_data got %h want 0000bbaa", out_data); end
        checks++; if (out_keep !== 4'b0011) begin errors++; $display("FAIL flush_keep got %b want 0011", out_keep); end
        drive(0, 8'h00, 1, 0);
        checks++; if (fifo_level !== 3'd1) begin errors++; $display("FAIL flush_second_level got %0d want 1", fifo_level); end
        drive(1, 8'hCC, 1, 0);
        checks++; if (fifo_level !== 3'd2) begin errors++; $display("FAIL flush_merge_level got %0d want 2", fifo_level); end
        drive(0, 8'h00, 0, 1);
        checks++; if (out_data !== 32'h000000CC || out_keep !== 4'b0001) begin errors++; $display("FAIL flush_merge_word got %h/%b want 000000cc/0001", out_data, out_keep); end
        drive(0, 8'h00, 0, 1);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_drain got %b want 0", out_valid); end
    endtask

    task automatic test_idle_flush();
        drive(1, 8'h5A, 0, 0);
        repeat (7) drive(0, 8'h00, 0, 0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL idle_early got %b want 0", out_valid); end
        drive(0, 8'h00, 0, 0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL idle_valid got %b want 1", out_valid); end
        checks++; if (out_data !== 32'h0000005A || out_keep !== 4'b0001) begin errors++; $display("FAIL idle_word got %h/%b want 0000005a/0001", out_data, out_keep); end
        drive(0, 8'h00, 0, 1);
    endtask

    task automatic test_overflow();
        logic [7:0] b[20];
        for (int i = 0; i < 20; i++) begin
            b[i] = 8'($urandom);
            drive(1, b[i], 0, 0);
        end
        checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL ovf_level got %0d want 4", fifo_level); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", overflow); end
`ifdef SD_STREAM_PACKER_STATS_EN
        checks++; if (drop_count !== 16'd1) begin errors++; $display("FAIL ovf_drop_count got %0d want 1", drop_count); end
`endif
        for (int w = 0; w < 4; w++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== {b[4*w+3], b[4*w+2], b[4*w+1], b[4*w]}) begin
                errors++;
                $display("FAIL ovf_drain%0d got %b/%h want 1/%h", w, out_valid, out_data, {b[4*w+3], b[4*w+2], b[4*w+1], b[4*w]});
            end
            drive(0, 8'h00, 0, 1);
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty got %b want 0", out_valid); end
    endtask

    task automatic test_full_pop();
        logic [7:0] b[20];
        reset_assert();
        reset_release();
        for (int i = 0; i < 20; i++) b[i] = 8'($urandom);
        for (int i = 0; i < 19; i++) drive(1, b[i], 0, 0);
        drive(1, b[19], 0, 1);
        checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL fullpop_level got %0d want 4", fifo_level); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fullpop_overflow got %b want 0", overflow); end
        checks++; if (out_data !== {b[7], b[6], b[5], b[4]}) begin errors++; $display("FAIL fullpop_head got %h want %h", out_data, {b[7], b[6], b[5], b[4]}); end
        repeat (3) drive(0, 8'h00, 0, 1);
        checks++; if (out_data !== {b[19], b[18], b[17], b[16]}) begin errors++; $display("FAIL fullpop_last got %h want %h", out_data, {b[19], b[18], b[17], b[16]}); end
        drive(0, 8'h00, 0, 1);
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 7; i++) drive(1, 8'(i + 1), 0, 0);
        reset_assert();
        checks++; if (out_valid !== 1'b0 || fifo_level !== 3'd0) begin errors++; $display("FAIL midreset_state got %b/%0d want 0/0", out_valid, fifo_level); end
        checks++; if (out_data !== 32'h0 || out_keep !== 4'h0) begin errors++; $display("FAIL midreset_data got %h/%b want 0/0", out_data, out_keep); end
        reset_release();
        drive(1, 8'hD1, 0, 0);
        drive(1, 8'hD2, 0, 0);
        drive(1, 8'hD3, 0, 0);
        drive(1, 8'hD4, 0, 0);
        checks++; if (fifo_level !== 3'd1) begin errors++; $display("FAIL midreset_level got %0d want 1", fifo_level); end
        checks++; if (out_data !== 32'hD4D3D2D1 || out_keep !== 4'b1111) begin errors++; $display("FAIL midreset_word got %h/%b want d4d3d2d1/1111", out_data, out_keep); end
        drive(0, 8'h00, 0, 1);
    endtask

    task automatic test_random();
        int dens, rdy_d;
        for (int p = 0; p < 20; p++) begin
            dens  = $urandom_range(0, 10);
            rdy_d = $urandom_range(0, 4);
            for (int c = 0; c < 80; c++) begin
                drive($urandom_range(0, 9) < dens, 8'($urandom), $urandom_range(0, 19) == 0, $urandom_range(0, 3) < rdy_d);
                checks++;
                if (out_valid !== (mq.size() > 0) || fifo_level !== 3'(mq.size()) || overflow !== ovf_m ||
                    (mq.size() > 0 && (out_data !== mq[0].d || out_keep !== mq[0].k))) begin
                    errors++;
                    $display("FAIL random p%0d c%0d got v=%b l=%0d o=%b %h/%b want v=%b l=%0d o=%b %h/%b",
                             p, c, out_valid, fifo_level, overflow, out_data, out_keep,
                             mq.size() > 0, mq.size(), ovf_m,
                             mq.size() > 0 ? mq[0].d : 32'h0, mq.size() > 0 ? mq[0].k : 4'h0);
                end
            end
        end
`ifdef SD_STREAM_PACKER_STATS_EN
        checks++; if (byte_count !== 32'(bytes_m)) begin errors++; $display("FAIL random_byte_count got %0d want %0d", byte_count, bytes_m); end
        checks++; if (drop_count !== 16'(drops_m)) begin errors++; $display("FAIL random_drop_count got %0d want %0d", drop_count, drops_m); end
`endif
    endtask

    initial begin
        test_reset();
        test_full_word();
        test_flush();
        test_idle_flush();
        test_overflow();
        test_full_pop();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
